spi_cmd_parser: RTL

SPI_CMD_PARSER -- requirements
Module: spi_cmd_parser

---
 rtl/spi_cmd_parser_if.sv | 25 ++
 rtl/spi_cmd_parser.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/spi_cmd_parser_if.sv
// Bus bundle between the SPI byte-level slave stage and the command parser.
// The slave modport is the parser's view; the master modport is the opposite side.
interface spi_cmd_parser_if;
    logic       ssel;
    logic       byte_valid;
    logic [7:0] byte_in;
    logic [7:0] byte_out;
    logic [7:0] status;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic       wr_en;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_err;

    modport slave (
        input  ssel, byte_valid, byte_in, status, rd_data,
        output byte_out, rd_addr, wr_en, wr_addr, wr_data, frame_err
    );

    modport master (
        output ssel, byte_valid, byte_in, status, rd_data,
        input  byte_out, rd_addr, wr_en, wr_addr, wr_data, frame_err
    );
endinterface

// File: rtl/spi_cmd_parser.sv
// SPI command parser: command byte selects read/write and start address, data bytes follow.
// Define SPI_CMD_AUTOINC_EN to step the address per data byte; otherwise it holds the command address.
// state | meaning
// IDLE  | no frame, byte_out follows status
// CMD   | frame open, waiting for command byte
// READ  | streaming register read data out
// WRITE | issuing register writes from received bytes
module spi_cmd_parser (
    input  logic              clk,
    input  logic              rst,
    spi_cmd_parser_if.slave   bus
);

`ifdef SPI_CMD_AUTOINC_EN
    localparam logic [6:0] ADDR_STEP = 7'd1;
`else
    localparam logic [6:0] ADDR_STEP = 7'd0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_ssel_q1, r_ssel_q2;
    logic [1:0]  r_sync_fill;
    logic        r_armed;
    logic        r_bv_d;
    logic [6:0]  r_addr, w_addr_nxt;
    logic [7:0]  r_byte_out, w_byte_out_nxt;
    logic        r_wr_en, w_wr_en_nxt;
    logic [6:0]  r_wr_addr, w_wr_addr_nxt;
    logic [7:0]  r_wr_data, w_wr_data_nxt;
    logic        r_frame_err, w_frame_err_nxt;

    logic        w_frame_active;
    logic        w_proc;
    logic [6:0]  w_addr_inc;
    logic [6:0]  w_rd_addr;

    assign w_frame_active = ~r_ssel_q2;
    assign w_proc         = r_bv_d;
    assign w_addr_inc     = r_addr + ADDR_STEP;

    // A frame only opens once the synchronised ssel has been genuinely seen high,
    // so a reset in the middle of a frame drops the remainder of that frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ssel_q1   <= 1'b1;
            r_ssel_q2   <= 1'b1;
            r_sync_fill <= 2'b00;
            r_armed     <= 1'b0;
            r_bv_d      <= 1'b0;
        end else begin
            r_ssel_q1   <= bus.ssel;
            r_ssel_q2   <= r_ssel_q1;
            r_sync_fill <= {r_sync_fill[0], 1'b1};
            r_bv_d      <= bus.byte_valid;
            if ((r_sync_fill == 2'b11) && !w_frame_active) begin
                r_armed <= 1'b1;
            end
        end
    end

    always_comb begin
        w_rd_addr = r_addr;
        case (r_state)
            ST_CMD:  w_rd_addr = bus.byte_in[6:0];
            ST_READ: w_rd_addr = w_addr_inc;
            default: w_rd_addr = r_addr;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= 7'd0;
            r_byte_out  <= 8'h00;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= 7'd0;
            r_wr_data   <= 8'h00;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_byte_out  <= w_byte_out_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_wr_addr   <= w_wr_addr_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    // A byte arriving as the frame closes is handled first; the level check returns to IDLE a clk later.
    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_byte_out_nxt  = r_byte_out;
        w_wr_en_nxt     = 1'b0;
        w_wr_addr_nxt   = r_wr_addr;
        w_wr_data_nxt   = r_wr_data;
        w_frame_err_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_byte_out_nxt = bus.status;
                if (w_frame_active && r_armed) begin
                    w_state_nxt = ST_CMD;
                end
            end
            ST_CMD: begin
                if (w_proc) begin
                    w_addr_nxt = bus.byte_in[6:0];
                    if (bus.byte_in[7]) begin
                        w_state_nxt    = ST_READ;
                        w_byte_out_nxt = bus.rd_data;
                    end else begin
                        w_state_nxt    = ST_WRITE;
                        w_byte_out_nxt = 8'h00;
                    end
                end else if (!w_frame_active) begin
                    w_frame_err_nxt = 1'b1;
                    w_state_nxt     = ST_IDLE;
                end
            end
            ST_READ: begin
                if (w_proc) begin
                    w_addr_nxt     = w_addr_inc;
                    w_byte_out_nxt = bus.rd_data;
                end else if (!w_frame_active) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (w_proc) begin
                    w_wr_en_nxt    = 1'b1;
                    w_wr_addr_nxt  = r_addr;
                    w_wr_data_nxt  = bus.byte_in;
                    w_addr_nxt     = w_addr_inc;
                    w_byte_out_nxt = 8'h00;
                end else if (!w_frame_active) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.byte_out  = r_byte_out;
    assign bus.rd_addr   = w_rd_addr;
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
    assign bus.frame_err = r_frame_err;

endmodule
